// File: rtl/alu_serial_pkg.sv
// Shared types and constants for the ALU result serial transmitter.
// Optional feature macro: ALU_SERIAL_PARITY_EN (appends an even-parity bit to each frame).
package alu_serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit counter must be able to index every frame bit including an optional parity bit
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

`ifdef ALU_SERIAL_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

endpackage

// File: rtl/alu_serial_tx_if.sv
// Load handshake and serial output bundle of the ALU result transmitter.
interface alu_serial_tx_if #(parameter int unsigned WIDTH = 8);

    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             ser_valid;
    logic             q;
    logic             qbar;
    logic             sof;
    logic             eof;
    logic             busy;

    modport master (
        output load_valid, load_data,
        input  load_ready, ser_valid, q, qbar, sof, eof, busy
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, ser_valid, q, qbar, sof, eof, busy
    );

endinterface

// File: rtl/alu_serial_tx_shift_reg.sv
// Parallel-load, right-shifting data register; bit 0 is the current serial bit.
module tx_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             eclk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sbit
);

    logic [WIDTH-1:0] sreg;

    // Clear, load (takes priority over shift), or shift right by one
    always_ff @(posedge eclk) begin
        if (!rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= {1'b0, sreg[WIDTH-1:1]};
        end
    end

    assign sbit = sreg[0];

endmodule

// File: rtl/alu_serial_tx.sv
// Bit-serial transmitter for ALU result words, LSB first on q/qbar with sof/eof strobes.
// Optional feature macro: ALU_SERIAL_PARITY_EN (even-parity bit after data bit WIDTH-1).
module alu_serial_tx
    import alu_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic           eclk,
    input  logic           rst,
    alu_serial_tx_if.slave bus
);

    localparam int unsigned CW   = cnt_width(WIDTH);
    localparam int unsigned FLEN = WIDTH + (PARITY_EN ? 1 : 0);
    localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          last;
    logic          accept;
    logic          shift;
    logic          sbit;
    logic          data_bit;

    assign last           = (state == SHIFT) && (cnt == LAST);
    assign bus.load_ready = rst && ((state == IDLE) || last);
    assign accept         = bus.load_valid && bus.load_ready;
    assign shift          = (state == SHIFT) && !accept;

    tx_shift_reg #(.WIDTH(WIDTH)) u_shift (
        .eclk  (eclk),
        .rst   (rst),
        .load  (accept),
        .shift (shift),
        .din   (bus.load_data),
        .sbit  (sbit)
    );

    // State and bit-counter register
    always_ff @(posedge eclk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: accept restarts a frame, even on the final bit of the current one
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (accept) begin
            state_nxt = SHIFT;
            cnt_nxt   = '0;
        end else if (last) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (state == SHIFT) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

`ifdef ALU_SERIAL_PARITY_EN
    logic par;

    // Even parity of the accepted word, sent after the last data bit
    always_ff @(posedge eclk) begin
        if (!rst) begin
            par <= 1'b0;
        end else if (accept) begin
            par <= ^bus.load_data;
        end
    end

    assign data_bit = (cnt == CW'(WIDTH)) ? par : sbit;
`else
    assign data_bit = sbit;
`endif

    assign bus.ser_valid = (state == SHIFT);
    assign bus.busy      = (state == SHIFT);
    assign bus.q         = (state == SHIFT) && data_bit;
    assign bus.qbar      = ~bus.q;
    assign bus.sof       = (state == SHIFT) && (cnt == '0);
    assign bus.eof       = last;

endmodule

// File: tb/tb_alu_serial_tx.sv
// Self-checking bench for alu_serial_tx: a queue of expected frame bits is the reference.
module tb_alu_serial_tx;
    import alu_serial_pkg::*;

    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic q;
        logic sof;
        logic eof;
    } fbit_t;

    logic  eclk;
    logic  rst;
    fbit_t expq[$];
    int    pass_cnt;
    int    total_cnt;

    alu_serial_tx_if #(.WIDTH(WIDTH)) bus ();

    alu_serial_tx #(.WIDTH(WIDTH)) dut (
        .eclk (eclk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    initial eclk = 1'b0;
    always #5 eclk = ~eclk;

    task automatic check(input string tag, input logic obs, input logic exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected bits of one frame, LSB first, with optional even parity bit
    task automatic push_frame(input logic [WIDTH-1:0] d);
        fbit_t f;
        for (int k = 0; k < WIDTH; k++) begin
            f.q   = d[k];
            f.sof = (k == 0);
            f.eof = (k == WIDTH - 1) && !PARITY_EN;
            expq.push_back(f);
        end
        if (PARITY_EN) begin
            f.q   = ^d;
            f.sof = 1'b0;
            f.eof = 1'b1;
            expq.push_back(f);
        end
    endtask

    // One clock: drive inputs, check outputs against the queue, advance the model
    task automatic cycle(input logic r, input logic v, input logic [WIDTH-1:0] d,
                         output logic acc, output logic qobs);
        logic  mready;
        fbit_t f;
        rst            = r;
        bus.load_valid = v;
        bus.load_data  = d;
        #1;
        mready = r && (expq.size() <= 1);
        check("load_ready", bus.load_ready, mready);
        if (expq.size() == 0) begin
            f.q   = 1'b0;
            f.sof = 1'b0;
            f.eof = 1'b0;
        end else begin
            f = expq[0];
        end
        check("ser_valid", bus.ser_valid, expq.size() != 0);
        check("busy", bus.busy, expq.size() != 0);
        check("q", bus.q, f.q);
        check("qbar", bus.qbar, ~f.q);
        check("sof", bus.sof, f.sof);
        check("eof", bus.eof, f.eof);
        qobs = bus.q;
        acc  = v && mready;
        @(posedge eclk);
        if (!r) begin
            expq.delete();
        end else begin
            if (expq.size() != 0) void'(expq.pop_front());
            if (acc) push_frame(d);
        end
        @(negedge eclk);
    endtask

    initial begin
        logic             acc;
        logic             qo;
        logic [WIDTH-1:0] seq;
        logic [WIDTH-1:0] w;
        pass_cnt       = 0;
        total_cnt      = 0;
        rst            = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = '0;
        @(posedge eclk);
        @(negedge eclk);

        // Reset held with load_valid high: nothing accepted
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h5A, acc, qo);
        cycle(1'b1, 1'b0, '0, acc, qo);
        cycle(1'b1, 1'b0, '0, acc, qo);

        // Single frame 8'hA5, recorded bit by bit
        cycle(1'b1, 1'b1, 8'hA5, acc, qo);
        check("accept_a5", acc, 1'b1);
        for (int k = 0; k < WIDTH; k++) begin
            cycle(1'b1, 1'b0, '0, acc, qo);
            seq[k] = qo;
        end
        check("a5_seq_lo", seq[3:0] == 4'h5, 1'b1);
        check("a5_seq_hi", seq[7:4] == 4'hA, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, acc, qo);

        // Parity-sensitive word 8'h07
        cycle(1'b1, 1'b1, 8'h07, acc, qo);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, '0, acc, qo);

        // Back-to-back: 8'hFF then 8'h00 held valid until accepted
        cycle(1'b1, 1'b1, 8'hFF, acc, qo);
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) cycle(1'b1, 1'b1, 8'h00, acc, qo);
        check("b2b_accepted", acc, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, '0, acc, qo);

        // Reset mid-frame, then a clean 8'h0F frame
        cycle(1'b1, 1'b1, 8'hF0, acc, qo);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, acc, qo);
        cycle(1'b0, 1'b1, 8'h33, acc, qo);
        cycle(1'b1, 1'b0, '0, acc, qo);
        cycle(1'b1, 1'b1, 8'h0F, acc, qo);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, '0, acc, qo);

        // Stall: load_valid high on non-final bits with changing data
        cycle(1'b1, 1'b1, 8'h3C, acc, qo);
        for (int i = 0; i < 4; i++) begin
            w = WIDTH'($urandom);
            cycle(1'b1, 1'b1, w, acc, qo);
            check("stall_no_accept", acc, 1'b0);
        end
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0, acc, qo);

        // Continuous streaming with random words
        for (int i = 0; i < 60; i++) begin
            w = WIDTH'($urandom);
            cycle(1'b1, 1'b1, w, acc, qo);
        end

        // Random valid, data and occasional reset
        for (int i = 0; i < 300; i++) begin
            w = WIDTH'($urandom);
            cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) != 0), w, acc, qo);
        end
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, '0, acc, qo);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
